// File: rtl/name_pkg.sv
// Shared glyph codes, glyph ROM and target name sequence for the name recognizer.
package name_pkg;

  localparam int COL_W               = 6;
  localparam int COLS_PER_GLYPH_DEF  = 4;
  localparam int NAME_LEN_DEF        = 8;
  localparam int BUF_W               = COL_W * COLS_PER_GLYPH_DEF;

  typedef enum logic [2:0] {
    GLYPH_NONE    = 3'd0,
    GLYPH_D       = 3'd1,
    GLYPH_A       = 3'd2,
    GLYPH_S       = 3'd3,
    GLYPH_U       = 3'd4,
    GLYPH_K       = 3'd5,
    GLYPH_O       = 3'd6,
    GLYPH_INVALID = 3'd7
  } glyph_t;

  // Column 0 sits in the low bits so buffer[n] maps to bits [6n +: 6].
  localparam logic [BUF_W-1:0] ROM_D = {6'h1E, 6'h21, 6'h21, 6'h3F};
  localparam logic [BUF_W-1:0] ROM_A = {6'h3F, 6'h09, 6'h09, 6'h3F};
  localparam logic [BUF_W-1:0] ROM_S = {6'h3D, 6'h25, 6'h25, 6'h37};
  localparam logic [BUF_W-1:0] ROM_U = {6'h3F, 6'h20, 6'h20, 6'h3F};
  localparam logic [BUF_W-1:0] ROM_K = {6'h31, 6'h0A, 6'h04, 6'h3F};
  localparam logic [BUF_W-1:0] ROM_O = {6'h3F, 6'h21, 6'h21, 6'h3F};

  localparam glyph_t NAME_SEQ [NAME_LEN_DEF] = '{
    GLYPH_D, GLYPH_A, GLYPH_S, GLYPH_U, GLYPH_K, GLYPH_O, GLYPH_D, GLYPH_A
  };

  localparam logic [COL_W-1:0] SEPARATOR = 6'b000000;

endpackage

// File: rtl/name_glyph_classify.sv
// Combinational exact-match lookup of a 4-column buffer against the glyph ROM.
module name_glyph_classify
  import name_pkg::*;
(
  input  logic [BUF_W-1:0] glyph_buf,
  output glyph_t           code
);

  always_comb begin
    code = GLYPH_INVALID;
    case (glyph_buf)
      ROM_D:   code = GLYPH_D;
      ROM_A:   code = GLYPH_A;
      ROM_S:   code = GLYPH_S;
      ROM_U:   code = GLYPH_U;
      ROM_K:   code = GLYPH_K;
      ROM_O:   code = GLYPH_O;
      default: code = GLYPH_INVALID;
    endcase
  end

endmodule

// File: rtl/blk_e611b6.sv
// Serial column recognizer: pulses y when glyphs D-A-S-U-K-O-D-A arrive in order.
// Optional NAME_GLYPH_CODE_EN adds glyph_valid/glyph_code outputs per framed glyph.
module blk_e611b6
  import name_pkg::*;
#(
  parameter int COLS_PER_GLYPH = COLS_PER_GLYPH_DEF,
  parameter int NAME_LEN       = NAME_LEN_DEF
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [5:0] a,
`ifdef NAME_GLYPH_CODE_EN
  output logic       glyph_valid,
  output logic [2:0] glyph_code,
`endif
  output logic       y
);

  localparam int CNT_W = $clog2(COLS_PER_GLYPH + 1);
  localparam int IDX_W = $clog2(NAME_LEN);
  localparam logic [CNT_W-1:0] CNT_FULL = CNT_W'(COLS_PER_GLYPH);
  localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(NAME_LEN - 1);

  logic [CNT_W-1:0] count_q;
  logic             ovf_q;
  logic [BUF_W-1:0] buf_q;
  logic [IDX_W-1:0] idx_q, idx_d;
  logic             y_q, hit;
  logic             is_sep, glyph_done;
  glyph_t           code_raw, code;

  name_glyph_classify u_classify (
    .glyph_buf (buf_q),
    .code      (code_raw)
  );

  assign is_sep     = (a == SEPARATOR);
  // Any separator that closes a non-empty frame produces a glyph verdict.
  assign glyph_done = is_sep && (count_q != '0);
  assign code       = (count_q == CNT_FULL && !ovf_q) ? code_raw : GLYPH_INVALID;

  always_comb begin
    idx_d = idx_q;
    hit   = 1'b0;
    if (glyph_done) begin
      if (code == NAME_SEQ[idx_q]) begin
        if (idx_q == IDX_LAST) begin
          idx_d = '0;
          hit   = 1'b1;
        end else begin
          idx_d = idx_q + 1'b1;
        end
      end else begin
        // A stray D may be the start of a fresh attempt.
        idx_d = (code == GLYPH_D) ? IDX_W'(1) : '0;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      count_q <= '0;
      ovf_q   <= 1'b0;
      buf_q   <= '0;
      idx_q   <= '0;
      y_q     <= 1'b0;
    end else begin
      if (is_sep) begin
        count_q <= '0;
        ovf_q   <= 1'b0;
        buf_q   <= '0;
      end else if (count_q < CNT_FULL) begin
        buf_q[count_q*COL_W +: COL_W] <= a;
        count_q <= count_q + 1'b1;
      end else begin
        ovf_q <= 1'b1;
      end
      idx_q <= idx_d;
      y_q   <= hit;
    end
  end

  assign y = y_q;

`ifdef NAME_GLYPH_CODE_EN
  logic       glyph_valid_q;
  logic [2:0] glyph_code_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      glyph_valid_q <= 1'b0;
      glyph_code_q  <= 3'd0;
    end else begin
      glyph_valid_q <= glyph_done;
      if (glyph_done) glyph_code_q <= code;
    end
  end

  assign glyph_valid = glyph_valid_q;
  assign glyph_code  = glyph_code_q;
`endif

endmodule

// File: tb/tb_blk_e611b6.sv
// Directed self-checking bench for blk_e611b6 (name recognizer).
module tb_blk_e611b6;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic [5:0] a = 6'd0;
  logic       y;
`ifdef NAME_GLYPH_CODE_EN
  logic       glyph_valid;
  logic [2:0] glyph_code;
`endif

  int n_checks = 0;
  int n_errors = 0;

  blk_e611b6 dut (
    .clk   (clk),
    .rst_n (rst_n),
    .a     (a),
`ifdef NAME_GLYPH_CODE_EN
    .glyph_valid (glyph_valid),
    .glyph_code  (glyph_code),
`endif
    .y     (y)
  );

  always #5 clk = ~clk;

  // Up to five columns, column 0 in the low bits.
  localparam logic [29:0] G_D     = {6'h00, 6'h1E, 6'h21, 6'h21, 6'h3F};
  localparam logic [29:0] G_A     = {6'h00, 6'h3F, 6'h09, 6'h09, 6'h3F};
  localparam logic [29:0] G_S     = {6'h00, 6'h3D, 6'h25, 6'h25, 6'h37};
  localparam logic [29:0] G_U     = {6'h00, 6'h3F, 6'h20, 6'h20, 6'h3F};
  localparam logic [29:0] G_K     = {6'h00, 6'h31, 6'h0A, 6'h04, 6'h3F};
  localparam logic [29:0] G_O     = {6'h00, 6'h3F, 6'h21, 6'h21, 6'h3F};
  localparam logic [29:0] G_S_BAD = {6'h00, 6'h3C, 6'h25, 6'h25, 6'h37};
  localparam logic [29:0] G_S5    = {6'h01, 6'h3D, 6'h25, 6'h25, 6'h37};

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic step(input logic [5:0] c, input logic exp_y, input string tag);
    @(negedge clk) a = c;
    @(posedge clk);
    #1 check(tag, 32'(y), 32'(exp_y));
  endtask

  task automatic send_glyph(input logic [29:0] g, input int ncols, input logic exp_y,
                            input logic [2:0] exp_code, input string tag);
    logic [29:0] gv;
    gv = g;
    for (int i = 0; i < ncols; i++) step(gv[i*6 +: 6], 1'b0, {tag, "_col"});
    step(6'd0, exp_y, {tag, "_sep"});
`ifdef NAME_GLYPH_CODE_EN
    check({tag, "_gvalid"}, 32'(glyph_valid), 32'd1);
    check({tag, "_gcode"}, 32'(glyph_code), 32'(exp_code));
`endif
  endtask

  task automatic send_name(input logic exp_end, input string tag);
    send_glyph(G_D, 4, 1'b0, 3'd1, {tag, "_D0"});
    send_glyph(G_A, 4, 1'b0, 3'd2, {tag, "_A0"});
    send_glyph(G_S, 4, 1'b0, 3'd3, {tag, "_S"});
    send_glyph(G_U, 4, 1'b0, 3'd4, {tag, "_U"});
    send_glyph(G_K, 4, 1'b0, 3'd5, {tag, "_K"});
    send_glyph(G_O, 4, 1'b0, 3'd6, {tag, "_O"});
    send_glyph(G_D, 4, 1'b0, 3'd1, {tag, "_D1"});
    send_glyph(G_A, 4, exp_end, 3'd2, {tag, "_A1"});
  endtask

  initial begin
    // Reset with random columns: y must stay low.
    rst_n = 1'b0;
    for (int i = 0; i < 6; i++) begin
      @(negedge clk) a = 6'($urandom);
      @(posedge clk);
      #1 check("reset_y", 32'(y), 32'd0);
    end
`ifdef NAME_GLYPH_CODE_EN
    check("reset_gcode", 32'(glyph_code), 32'd0);
`endif
    @(negedge clk) begin a = 6'd0; rst_n = 1'b1; end
    step(6'd0, 1'b0, "idle");

    send_name(1'b1, "name1");
    step(6'd0, 1'b0, "post_pulse");
`ifdef NAME_GLYPH_CODE_EN
    check("idle_gvalid", 32'(glyph_valid), 32'd0);
`endif

    // Corrupted S, then a clean name.
    send_glyph(G_D, 4, 1'b0, 3'd1, "bad_D");
    send_glyph(G_A, 4, 1'b0, 3'd2, "bad_A");
    send_glyph(G_S_BAD, 4, 1'b0, 3'd7, "bad_S");
    send_glyph(G_U, 4, 1'b0, 3'd4, "bad_U");
    send_glyph(G_K, 4, 1'b0, 3'd5, "bad_K");
    send_glyph(G_O, 4, 1'b0, 3'd6, "bad_O");
    send_glyph(G_D, 4, 1'b0, 3'd1, "bad_D1");
    send_glyph(G_A, 4, 1'b0, 3'd2, "bad_A1");
    send_name(1'b1, "name2");

    // Restart on D: D,A,D,A,S,U,K,O,D,A.
    send_glyph(G_D, 4, 1'b0, 3'd1, "rst_D");
    send_glyph(G_A, 4, 1'b0, 3'd2, "rst_A");
    send_name(1'b1, "restart");

    // Five-column S invalidates.
    send_glyph(G_D, 4, 1'b0, 3'd1, "f5_D");
    send_glyph(G_A, 4, 1'b0, 3'd2, "f5_A");
    send_glyph(G_S5, 5, 1'b0, 3'd7, "f5_S");
    send_glyph(G_U, 4, 1'b0, 3'd4, "f5_U");
    send_glyph(G_K, 4, 1'b0, 3'd5, "f5_K");
    send_glyph(G_O, 4, 1'b0, 3'd6, "f5_O");
    send_glyph(G_D, 4, 1'b0, 3'd1, "f5_D1");
    send_glyph(G_A, 4, 1'b0, 3'd2, "f5_A1");

    // Three-column U invalidates.
    send_glyph(G_D, 4, 1'b0, 3'd1, "f3_D");
    send_glyph(G_A, 4, 1'b0, 3'd2, "f3_A");
    send_glyph(G_S, 4, 1'b0, 3'd3, "f3_S");
    send_glyph(G_U, 3, 1'b0, 3'd7, "f3_U");
    send_glyph(G_K, 4, 1'b0, 3'd5, "f3_K");
    send_glyph(G_O, 4, 1'b0, 3'd6, "f3_O");
    send_glyph(G_D, 4, 1'b0, 3'd1, "f3_D1");
    send_glyph(G_A, 4, 1'b0, 3'd2, "f3_A1");

    // Extra separators inside the name are harmless.
    send_glyph(G_D, 4, 1'b0, 3'd1, "gap_D");
    send_glyph(G_A, 4, 1'b0, 3'd2, "gap_A");
    send_glyph(G_S, 4, 1'b0, 3'd3, "gap_S");
    step(6'd0, 1'b0, "gap_idle0");
    step(6'd0, 1'b0, "gap_idle1");
    send_glyph(G_U, 4, 1'b0, 3'd4, "gap_U");
    send_glyph(G_K, 4, 1'b0, 3'd5, "gap_K");
    send_glyph(G_O, 4, 1'b0, 3'd6, "gap_O");
    send_glyph(G_D, 4, 1'b0, 3'd1, "gap_D1");
    send_glyph(G_A, 4, 1'b1, 3'd2, "gap_A1");

    // Back-to-back names.
    send_name(1'b1, "b2b_1");
    send_name(1'b1, "b2b_2");

    // Async reset while y is high clears it without a clock edge.
    send_name(1'b1, "pre_rst");
    #1 rst_n = 1'b0;
    #1 check("async_rst_y", 32'(y), 32'd0);
`ifdef NAME_GLYPH_CODE_EN
    check("async_rst_gcode", 32'(glyph_code), 32'd0);
`endif
    @(negedge clk) rst_n = 1'b1;

    // Reset after K, then only O,D,A: no pulse.
    send_glyph(G_D, 4, 1'b0, 3'd1, "mid_D");
    send_glyph(G_A, 4, 1'b0, 3'd2, "mid_A");
    send_glyph(G_S, 4, 1'b0, 3'd3, "mid_S");
    send_glyph(G_U, 4, 1'b0, 3'd4, "mid_U");
    send_glyph(G_K, 4, 1'b0, 3'd5, "mid_K");
    @(negedge clk);
    #2 rst_n = 1'b0;
    #1 check("mid_rst_y", 32'(y), 32'd0);
    @(negedge clk) rst_n = 1'b1;
    send_glyph(G_O, 4, 1'b0, 3'd6, "tail_O");
    send_glyph(G_D, 4, 1'b0, 3'd1, "tail_D");
    send_glyph(G_A, 4, 1'b0, 3'd2, "tail_A");
    step(6'd0, 1'b0, "tail_idle");

    send_name(1'b1, "recover");
    step(6'd0, 1'b0, "final_idle");

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
